// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, FSM state encoding and saturation limits.
package alu_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_NIB   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/addsub_serial_16bit_if.sv
// Operand/result handshake bundle for the nibble-serial add/sub unit.
interface addsub_serial_16bit_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] SUM;
  logic             OVFL;

  modport master (
    output in_valid, A, B, sub, out_ready,
    input  in_ready, out_valid, SUM, OVFL
  );

  modport slave (
    input  in_valid, A, B, sub, out_ready,
    output in_ready, out_valid, SUM, OVFL
  );

endinterface

// File: rtl/addsub_digit_4bit.sv
// Combinational NIB-bit carry-lookahead digit adder, reused once per CALC cycle.
module addsub_digit_4bit
  import alu_pkg::*;
#(
  parameter int unsigned NIB = DEF_NIB
) (
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  output logic [NIB-1:0] s,
  output logic           cout
);

  logic [NIB-1:0] g;
  logic [NIB-1:0] p;
  logic [NIB:0]   c;
  logic           grp_g;
  logic           grp_p;
  int unsigned    j;

  // Each carry is formed from the group generate/propagate of bits [i:0] and cin.
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    grp_g = 1'b0;
    grp_p = 1'b0;
    j     = 0;
    c[0]  = cin;
    for (int unsigned i = 0; i < NIB; i++) begin
      grp_g = g[i];
      grp_p = p[i];
      for (int unsigned k = 0; k < i; k++) begin
        j     = i - 1 - k;
        grp_g = grp_g | (grp_p & g[j]);
        grp_p = grp_p & p[j];
      end
      c[i+1] = grp_g | (grp_p & cin);
    end
    s    = p ^ c[NIB-1:0];
    cout = c[NIB];
  end

endmodule

// File: rtl/addsub_serial_16bit.sv
// Nibble-serial signed saturating adder/subtractor with valid/ready handshakes.
module addsub_serial_16bit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NIB   = DEF_NIB
) (
  input  logic                  clk,
  input  logic                  rst,
  addsub_serial_16bit_if.slave  bus
);

  localparam int unsigned      STEPS = WIDTH / NIB;
  localparam int unsigned      CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0]    LAST  = CW'(STEPS - 1);
  localparam logic [WIDTH-1:0] SAT_P = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_N = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             sign_a;
  logic             sign_b;
  logic [NIB-1:0]   dig_s;
  logic             dig_c;
  logic [WIDTH-1:0] sum_next;
  logic             ov;

  addsub_digit_4bit #(.NIB(NIB)) u_digit (
    .a    (op_a[NIB-1:0]),
    .b    (op_b[NIB-1:0]),
    .cin  (carry),
    .s    (dig_s),
    .cout (dig_c)
  );

  // Operand sign bits are kept aside because the operand registers shift out.
  always_comb begin
    sum_next      = {dig_s, acc[WIDTH-1:NIB]};
    ov            = (sign_a == sign_b) && (sum_next[WIDTH-1] != sign_a);
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      carry    <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      bus.SUM  <= '0;
      bus.OVFL <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a   <= bus.A;
            op_b   <= bus.sub ? ~bus.B : bus.B;
            sign_a <= bus.A[WIDTH-1];
            sign_b <= bus.sub ? ~bus.B[WIDTH-1] : bus.B[WIDTH-1];
            carry  <= bus.sub;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          acc   <= sum_next;
          op_a  <= op_a >> NIB;
          op_b  <= op_b >> NIB;
          carry <= dig_c;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            bus.SUM  <= ov ? (sign_a ? SAT_N : SAT_P) : sum_next;
            bus.OVFL <= ov;
            state    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
